vga_capture: RTL and testbench



---
 rtl/vga_capture_if.sv | 23 ++
 rtl/vga_capture.sv | 267 ++++++++++++++++++++++++++
 tb/tb_vga_capture.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// vga_capture_if
//   Framebuffer write bus produced by vga_capture.
//   wr_en   : one-cycle pixel write strobe
//   wr_x    : pixel column (10 bits)
//   wr_y    : pixel row (10 bits)
//   wr_data : pixel colour, 24 bits {r,g,b}, or 16 bits RGB565 when
//             VGA_CAP_RGB565_EN is defined
//   Modports: master (capture side, drives the bus), slave (memory side).
interface vga_capture_if;
`ifdef VGA_CAP_RGB565_EN
  localparam int DATA_W = 16;
`else
  localparam int DATA_W = 24;
`endif

  logic              wr_en;
  logic [9:0]        wr_x;
  logic [9:0]        wr_y;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_x, output wr_y, output wr_data);
  modport slave  (input  wr_en, input  wr_x, input  wr_y, input  wr_data);
endinterface

// File: rtl/vga_capture.sv
// vga_capture
//   Pixel-clock VGA sink. Registers the incoming HSYNC/VSYNC/blank/RGB
//   stream, measures line length (clocks) and frame length (lines), locks
//   once LOCK_FRAMES consecutive frame measurements agree, and while locked
//   emits one framebuffer write per active pixel with recovered (x, y).
//
//   Build option: define VGA_CAP_RGB565_EN to pack wr_data as 16-bit RGB565
//   {r[7:3], g[7:2], b[7:3]}; otherwise wr_data is 24-bit {r, g, b}.
//
//   Ports
//     clk_25      in   pixel clock, rising edge
//     rst         in   synchronous reset, active-high
//     vga_hs      in   horizontal sync, active-low
//     vga_vs      in   vertical sync, active-low
//     vga_blank   in   high = active video pixel
//     vga_r/g/b   in   8-bit colour components
//     wr          mst  framebuffer write bus (wr_en, wr_x, wr_y, wr_data)
//     frame_done  out  one-cycle pulse per matching frame while locked
//     locked      out  timing locked
//     h_total     out  last measured line length in clocks
//     v_total     out  last measured frame length in lines
//     err         out  one-cycle pulse on lock loss
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk_25,
  input  logic                rst,
  input  logic                vga_hs,
  input  logic                vga_vs,
  input  logic                vga_blank,
  input  logic [7:0]          vga_r,
  input  logic [7:0]          vga_g,
  input  logic [7:0]          vga_b,
  vga_capture_if.master       wr,
  output logic                frame_done,
  output logic                locked,
  output logic [9:0]          h_total,
  output logic [9:0]          v_total,
  output logic                err
);

`ifdef VGA_CAP_RGB565_EN
  localparam int DATA_W = 16;
`else
  localparam int DATA_W = 24;
`endif

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

  // ---------------------------------------------------------------- input stage
  logic              hs_q_reg, hs_d_reg;
  logic              vs_q_reg, vs_d_reg;
  logic              blank_q_reg, blank_d_reg;
  logic [DATA_W-1:0] pix_q_reg;
  logic [DATA_W-1:0] pix_in;

  // Colour is packed on the way in so only the bits that reach the
  // framebuffer are stored.
`ifdef VGA_CAP_RGB565_EN
  assign pix_in = {vga_r[7:3], vga_g[7:2], vga_b[7:3]};
`else
  assign pix_in = {vga_r, vga_g, vga_b};
`endif

  logic hs_fall, vs_fall, blank_fall;
  assign hs_fall    = hs_d_reg & ~hs_q_reg;
  assign vs_fall    = vs_d_reg & ~vs_q_reg;
  assign blank_fall = blank_d_reg & ~blank_q_reg;

  // ------------------------------------------------------------ timing counters
  logic [9:0] hcnt_reg, hcnt_next;
  logic [9:0] vcnt_reg, vcnt_next;
  logic [9:0] line_len_reg, line_len_next;
  logic [9:0] h_total_reg, h_total_next;
  logic [9:0] v_total_reg, v_total_next;
  logic [9:0] h_meas, v_meas;
  logic       sat_hit;

  always_comb begin
    hcnt_next = hs_fall ? 10'd0 : sat_inc(hcnt_reg);
    // A line ending on this very cycle is the most recent one.
    h_meas    = hs_fall ? sat_inc(hcnt_reg) : line_len_reg;
    line_len_next = h_meas;
    // An hs_fall coinciding with vs_fall belongs to the frame that is ending.
    v_meas    = hs_fall ? sat_inc(vcnt_reg) : vcnt_reg;
    if (vs_fall) begin
      vcnt_next = 10'd0;
    end else if (hs_fall) begin
      vcnt_next = sat_inc(vcnt_reg);
    end else begin
      vcnt_next = vcnt_reg;
    end
    h_total_next = vs_fall ? h_meas : h_total_reg;
    v_total_next = vs_fall ? v_meas : v_total_reg;
  end

  // Level-sensitive: while either counter sits at its ceiling the input has
  // no usable timing, so the FSM is held in SEARCH.
  assign sat_hit = (hcnt_reg == CNT_MAX) || (vcnt_reg == CNT_MAX);

  // ------------------------------------------------------------------------ FSM
  state_t     state_reg, state_next;
  logic [9:0] ref_h_reg, ref_h_next;
  logic [9:0] ref_v_reg, ref_v_next;
  logic [3:0] match_cnt_reg, match_cnt_next;
  logic       locked_reg, locked_next;
  logic       frame_done_reg, frame_done_next;
  logic       err_reg, err_next;
  logic       meas_match;

  assign meas_match = (h_meas == ref_h_reg) && (v_meas == ref_v_reg);

  always_comb begin
    state_next      = state_reg;
    ref_h_next      = ref_h_reg;
    ref_v_next      = ref_v_reg;
    match_cnt_next  = match_cnt_reg;
    frame_done_next = 1'b0;
    err_next        = 1'b0;
    if (sat_hit) begin
      state_next     = SEARCH;
      match_cnt_next = 4'd0;
      err_next       = (state_reg == LOCKED);
    end else if (vs_fall) begin
      case (state_reg)
        SEARCH: begin
          // The frame that just ended began before we were watching.
          state_next = MEASURE;
        end
        MEASURE: begin
          ref_h_next     = h_meas;
          ref_v_next     = v_meas;
          match_cnt_next = 4'd1;
          state_next     = (LOCK_FRAMES <= 1) ? LOCKED : VERIFY;
        end
        VERIFY: begin
          if (meas_match) begin
            match_cnt_next = match_cnt_reg + 4'd1;
            if (match_cnt_reg + 4'd1 >= 4'(LOCK_FRAMES)) begin
              state_next = LOCKED;
            end
          end else begin
            ref_h_next     = h_meas;
            ref_v_next     = v_meas;
            match_cnt_next = 4'd1;
          end
        end
        LOCKED: begin
          if (meas_match) begin
            frame_done_next = 1'b1;
          end else begin
            ref_h_next     = h_meas;
            ref_v_next     = v_meas;
            match_cnt_next = 4'd1;
            state_next     = VERIFY;
            err_next       = 1'b1;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
    locked_next = (state_next == LOCKED);
  end

  // ------------------------------------------------------- coordinates / write
  logic [9:0]        x_reg, x_next;
  logic [9:0]        y_reg, y_next;
  logic              wr_en_reg, wr_en_next;
  logic [9:0]        wr_x_reg, wr_x_next;
  logic [9:0]        wr_y_reg, wr_y_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;

  always_comb begin
    // x_reg holds the column of the pixel currently in the input register.
    x_next = blank_q_reg ? sat_inc(x_reg) : 10'd0;
    if (vs_fall) begin
      y_next = 10'd0;
    end else if (blank_fall) begin
      y_next = sat_inc(y_reg);
    end else begin
      y_next = y_reg;
    end
    wr_en_next   = locked_reg && blank_q_reg
                   && ({1'b0, x_reg} < 11'(H_ACTIVE))
                   && ({1'b0, y_reg} < 11'(V_ACTIVE));
    wr_x_next    = wr_en_next ? x_reg     : wr_x_reg;
    wr_y_next    = wr_en_next ? y_reg     : wr_y_reg;
    wr_data_next = wr_en_next ? pix_q_reg : wr_data_reg;
  end

  // ------------------------------------------------------------------ registers
  always_ff @(posedge clk_25) begin
    if (rst) begin
      // Syncs idle high, so their history starts high: no false edge.
      hs_q_reg       <= 1'b1;
      hs_d_reg       <= 1'b1;
      vs_q_reg       <= 1'b1;
      vs_d_reg       <= 1'b1;
      blank_q_reg    <= 1'b0;
      blank_d_reg    <= 1'b0;
      pix_q_reg      <= '0;
      hcnt_reg       <= 10'd0;
      vcnt_reg       <= 10'd0;
      line_len_reg   <= 10'd0;
      h_total_reg    <= 10'd0;
      v_total_reg    <= 10'd0;
      state_reg      <= SEARCH;
      ref_h_reg      <= 10'd0;
      ref_v_reg      <= 10'd0;
      match_cnt_reg  <= 4'd0;
      locked_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      x_reg          <= 10'd0;
      y_reg          <= 10'd0;
      wr_en_reg      <= 1'b0;
      wr_x_reg       <= 10'd0;
      wr_y_reg       <= 10'd0;
      wr_data_reg    <= '0;
    end else begin
      hs_q_reg       <= vga_hs;
      hs_d_reg       <= hs_q_reg;
      vs_q_reg       <= vga_vs;
      vs_d_reg       <= vs_q_reg;
      blank_q_reg    <= vga_blank;
      blank_d_reg    <= blank_q_reg;
      pix_q_reg      <= pix_in;
      hcnt_reg       <= hcnt_next;
      vcnt_reg       <= vcnt_next;
      line_len_reg   <= line_len_next;
      h_total_reg    <= h_total_next;
      v_total_reg    <= v_total_next;
      state_reg      <= state_next;
      ref_h_reg      <= ref_h_next;
      ref_v_reg      <= ref_v_next;
      match_cnt_reg  <= match_cnt_next;
      locked_reg     <= locked_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      wr_en_reg      <= wr_en_next;
      wr_x_reg       <= wr_x_next;
      wr_y_reg       <= wr_y_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign wr.wr_en   = wr_en_reg;
  assign wr.wr_x    = wr_x_reg;
  assign wr.wr_y    = wr_y_reg;
  assign wr.wr_data = wr_data_reg;
  assign frame_done = frame_done_reg;
  assign locked     = locked_reg;
  assign h_total    = h_total_reg;
  assign v_total    = v_total_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Directed bench for vga_capture. Video timing is scaled down to keep run
//   time short: 100-clock lines (hs low 12 clocks), 20-line frames (vs low
//   2 lines, vs edges coincident with hs edges). Blank is driven 68 wide by
//   13 lines against H_ACTIVE=64 / V_ACTIVE=12, so the last driven column
//   and row must be suppressed: 768 writes per locked frame.
`timescale 1ns/1ps
module tb_vga_capture;

  localparam int HT       = 100;
  localparam int HA_DRV   = 68;
  localparam int HS_START = 76;
  localparam int HS_LEN   = 12;
  localparam int VT       = 20;
  localparam int VA_DRV   = 13;
  localparam int VS_LINE  = 15;
  localparam int H_ACT    = 64;
  localparam int V_ACT    = 12;

`ifdef VGA_CAP_RGB565_EN
  localparam int DW = 16;
  localparam logic [15:0] COLOUR_EXP = 16'hFC00;
`else
  localparam int DW = 24;
  localparam logic [23:0] COLOUR_EXP = 24'hFF8001;
`endif

  logic       clk_25 = 1'b0;
  logic       rst;
  logic       vga_hs, vga_vs, vga_blank;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       frame_done, locked, err;
  logic [9:0] h_total, v_total;

  vga_capture_if wr();

  vga_capture #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LOCK_FRAMES(2)) dut (
    .clk_25(clk_25), .rst(rst),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr(wr),
    .frame_done(frame_done), .locked(locked),
    .h_total(h_total), .v_total(v_total), .err(err)
  );

  always #20 clk_25 = ~clk_25;

  int checks = 0;
  int errors = 0;

  int ne_idx = 0;
  int wr_cnt, bad_data, fd_cnt, fd_idx, err_cnt, err_idx, wr_after_err;
  int rise_idx, fall_idx, last_vs_idx, frame_start_idx, first_wr_idx;
  int first_x, first_y, last_x, last_y, ex, ey;
  logic [DW-1:0] last_data;
  bit   solid = 0;
  bit   rst_chk = 0;
  logic locked_prev = 1'b0;

  function automatic logic [DW-1:0] pix_word(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
`ifdef VGA_CAP_RGB565_EN
    return {r[7:3], g[7:2], b[7:3]};
`else
    return {r, g, b};
`endif
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; bad_data = 0; fd_cnt = 0; fd_idx = -1; err_cnt = 0; err_idx = -1;
    wr_after_err = 0; rise_idx = -1; fall_idx = -1; first_wr_idx = -1;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; ex = 0; ey = 0;
    last_data = '0;
  endtask

  // Advance to the next falling edge and observe the outputs settled there.
  task automatic step();
    logic [DW-1:0] exp_w;
    logic [7:0]    exb, eyb;
    @(negedge clk_25);
    ne_idx++;
    if (rst_chk) begin
      rst_chk = 0;
      checks++;
      if ({wr.wr_en, wr.wr_x, wr.wr_y, wr.wr_data, frame_done, locked, h_total, v_total, err} !== '0) begin
        errors++;
        $display("FAIL reset_midline: en=%b x=%0d y=%0d data=%h fd=%b lk=%b ht=%0d vt=%0d err=%b, required all 0",
                 wr.wr_en, wr.wr_x, wr.wr_y, wr.wr_data, frame_done, locked, h_total, v_total, err);
      end
    end
    if (wr.wr_en) begin
      if (wr_cnt == 0) begin
        first_x = int'(wr.wr_x); first_y = int'(wr.wr_y); first_wr_idx = ne_idx;
      end
      last_x = int'(wr.wr_x); last_y = int'(wr.wr_y); last_data = wr.wr_data;
      wr_cnt++;
      exb = ex[7:0];
      eyb = ey[7:0];
      exp_w = solid ? COLOUR_EXP : pix_word(exb, eyb, 8'hA5);
      if (wr.wr_x !== 10'(ex) || wr.wr_y !== 10'(ey) || wr.wr_data !== exp_w) bad_data++;
      if (err_cnt > 0) wr_after_err++;
      ex++;
      if (ex == H_ACT) begin ex = 0; ey++; end
    end
    if (frame_done) begin fd_cnt++; fd_idx = ne_idx; end
    if (err) begin err_cnt++; err_idx = ne_idx; end
    if (locked && !locked_prev) rise_idx = ne_idx;
    if (!locked && locked_prev) fall_idx = ne_idx;
    locked_prev = locked;
  endtask

  task automatic drive_frame(input int htot, input bit hs_stuck, input bit solid_px,
                             input int rst_line);
    bit act, vs_low;
    logic [7:0] hb, vb;
    solid = solid_px;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < htot; h++) begin
        step();
        if (v == 0 && h == 0) frame_start_idx = ne_idx;
        act    = (h < HA_DRV) && (v < VA_DRV);
        vs_low = (v == VS_LINE && h >= HS_START) || (v == VS_LINE + 1) ||
                 (v == VS_LINE + 2 && h < HS_START);
        if (vs_low && vga_vs) last_vs_idx = ne_idx;
        vga_vs    = !vs_low;
        vga_hs    = hs_stuck ? 1'b1 : !(h >= HS_START && h < HS_START + HS_LEN);
        vga_blank = act;
        hb = h[7:0];
        vb = v[7:0];
        if (!act) begin
          vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
        end else if (solid_px) begin
          vga_r = 8'hFF; vga_g = 8'h80; vga_b = 8'h01;
        end else begin
          vga_r = hb; vga_g = vb; vga_b = 8'hA5;
        end
        if (v == rst_line && h == 10) begin
          rst = 1'b1; rst_chk = 1;
        end else begin
          rst = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank = 1'b0;
    vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
    clear_stats();
    repeat (3) step();
    checks++; if (wr.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr.wr_en); end
    checks++; if (wr.wr_x !== 10'd0) begin errors++; $display("FAIL reset_wr_x: got %0d want 0", wr.wr_x); end
    checks++; if (wr.wr_y !== 10'd0) begin errors++; $display("FAIL reset_wr_y: got %0d want 0", wr.wr_y); end
    checks++; if (wr.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr.wr_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (h_total !== 10'd0) begin errors++; $display("FAIL reset_h_total: got %0d want 0", h_total); end
    checks++; if (v_total !== 10'd0) begin errors++; $display("FAIL reset_v_total: got %0d want 0", v_total); end
    rst = 1'b0;
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_lock();
    clear_stats();
    repeat (3) drive_frame(HT, 0, 0, -1);
    checks++; if (rise_idx !== last_vs_idx + 2) begin errors++; $display("FAIL lock_rise_time: got idx %0d want %0d", rise_idx, last_vs_idx + 2); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_state: got %b want 1", locked); end
    checks++; if (h_total !== 10'd100) begin errors++; $display("FAIL lock_h_total: got %0d want 100", h_total); end
    checks++; if (v_total !== 10'd20) begin errors++; $display("FAIL lock_v_total: got %0d want 20", v_total); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL lock_err: got %0d pulses want 0", err_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL lock_no_writes: got %0d writes want 0", wr_cnt); end
    $display("test_lock: locked at idx %0d, h_total=%0d v_total=%0d", rise_idx, h_total, v_total);
  endtask

  task automatic test_frame_write();
    clear_stats();
    drive_frame(HT, 0, 0, -1);
    checks++; if (wr_cnt !== H_ACT * V_ACT) begin errors++; $display("FAIL write_count: got %0d want %0d", wr_cnt, H_ACT * V_ACT); end
    checks++; if (first_x !== 0 || first_y !== 0) begin errors++; $display("FAIL write_first: got (%0d,%0d) want (0,0)", first_x, first_y); end
    checks++; if (last_x !== H_ACT - 1 || last_y !== V_ACT - 1) begin errors++; $display("FAIL write_last: got (%0d,%0d) want (%0d,%0d)", last_x, last_y, H_ACT - 1, V_ACT - 1); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL write_data: got %0d bad writes want 0", bad_data); end
    checks++; if (first_wr_idx !== frame_start_idx + 2) begin errors++; $display("FAIL write_latency: got idx %0d want %0d", first_wr_idx, frame_start_idx + 2); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
    checks++; if (fd_idx !== last_vs_idx + 2) begin errors++; $display("FAIL frame_done_time: got idx %0d want %0d", fd_idx, last_vs_idx + 2); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL write_err: got %0d pulses want 0", err_cnt); end
    $display("test_frame_write: %0d writes, first (%0d,%0d) last (%0d,%0d)", wr_cnt, first_x, first_y, last_x, last_y);
  endtask

  task automatic test_line_change();
    clear_stats();
    drive_frame(HT + 1, 0, 0, -1);
    checks++; if (fall_idx !== last_vs_idx + 2) begin errors++; $display("FAIL change_unlock_time: got idx %0d want %0d", fall_idx, last_vs_idx + 2); end
    checks++; if (err_cnt !== 1 || err_idx !== last_vs_idx + 2) begin errors++; $display("FAIL change_err: got %0d pulses at %0d want 1 at %0d", err_cnt, err_idx, last_vs_idx + 2); end
    checks++; if (h_total !== 10'd101) begin errors++; $display("FAIL change_h_total: got %0d want 101", h_total); end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL change_frame_done: got %0d want 0", fd_cnt); end
    drive_frame(HT, 0, 0, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL change_relock_early: got %b want 0", locked); end
    drive_frame(HT, 0, 0, -1);
    checks++; if (locked !== 1'b1 || rise_idx !== last_vs_idx + 2) begin errors++; $display("FAIL change_relock: got lk=%b idx %0d want 1 idx %0d", locked, rise_idx, last_vs_idx + 2); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL change_err_total: got %0d want 1", err_cnt); end
    $display("test_line_change: relocked at idx %0d, h_total=%0d", rise_idx, h_total);
  endtask

  task automatic test_hs_stuck();
    clear_stats();
    drive_frame(HT, 1, 0, -1);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stuck_err: got %0d pulses want 1", err_cnt); end
    checks++; if (locked !== 1'b0 || fall_idx !== err_idx) begin errors++; $display("FAIL stuck_unlock: got lk=%b fall %0d want 0 fall %0d", locked, fall_idx, err_idx); end
    checks++; if (wr_after_err !== 0) begin errors++; $display("FAIL stuck_writes: got %0d writes after err want 0", wr_after_err); end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL stuck_frame_done: got %0d want 0", fd_cnt); end
    $display("test_hs_stuck: err at idx %0d, frame start idx %0d", err_idx, frame_start_idx);
  endtask

  task automatic test_reset_midline();
    clear_stats();
    drive_frame(HT, 0, 0, 3);
    drive_frame(HT, 0, 0, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early: got %b want 0", locked); end
    drive_frame(HT, 0, 0, -1);
    checks++; if (locked !== 1'b1 || rise_idx !== last_vs_idx + 2) begin errors++; $display("FAIL rst_relock: got lk=%b idx %0d want 1 idx %0d", locked, rise_idx, last_vs_idx + 2); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rst_err: got %0d pulses want 0", err_cnt); end
    $display("test_reset_midline: relocked at idx %0d", rise_idx);
  endtask

  task automatic test_colour();
    clear_stats();
    drive_frame(HT, 0, 1, -1);
    checks++; if (wr_cnt !== H_ACT * V_ACT) begin errors++; $display("FAIL colour_count: got %0d want %0d", wr_cnt, H_ACT * V_ACT); end
    checks++; if (last_data !== COLOUR_EXP) begin errors++; $display("FAIL colour_data: got %h want %h", last_data, COLOUR_EXP); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL colour_all: got %0d bad writes want 0", bad_data); end
    $display("test_colour: wr_data=%h", last_data);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frame_write();
    test_line_change();
    test_hs_stuck();
    test_reset_midline();
    test_colour();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
